// File: rtl/regfile_dump_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_pkg
// Description : Shared types and constants for the register-file dump reader.
//               Holds the dump FSM state encoding and the register index width.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_dump_pkg;

    // Width of a register index (x0..x31).
    localparam int REG_IDX_W = 5;

    // Dump sequencer states, explicitly encoded.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dump_state_t;

endpackage : regfile_dump_pkg
`default_nettype wire

// File: rtl/regfile_dump.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump
// Description : Debug reader for the integer register file. A start pulse
//               walks x0..x(NREGS-1) through one combinational read port,
//               captures each value and streams it out as an indexed word
//               over a valid/ready handshake. halt_req freezes the core for
//               the whole dump so the snapshot is self-consistent.
// Ports       : clk, reset        - clock, synchronous active-high reset
//               start             - dump request, honoured only when idle
//               rf_addr / rf_data - register-file read port
//               out_valid/ready   - output handshake
//               out_index/data    - register index and captured value
//               out_last          - marks the word for index NREGS-1
//               busy / halt_req   - dump in progress / core stall request
//               done              - one-cycle pulse after the final word
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump
    import regfile_dump_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int XLEN  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic [REG_IDX_W-1:0] rf_addr,
    input  logic [XLEN-1:0]      rf_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REG_IDX_W-1:0] out_index,
    output logic [XLEN-1:0]      out_data,
    output logic                 out_last,
    output logic                 busy,
    output logic                 halt_req,
    output logic                 done
);

    // Index of the final register; the walk stops here and never wraps.
    localparam logic [REG_IDX_W-1:0] c_LAST_IDX = REG_IDX_W'(NREGS - 1);

    dump_state_t          r_state;
    logic [REG_IDX_W-1:0] r_idx;
    logic [REG_IDX_W-1:0] r_out_index;
    logic [XLEN-1:0]      r_out_data;
    logic                 r_out_valid;
    logic                 r_done;

    logic                 w_at_last;

    assign w_at_last = (r_idx == c_LAST_IDX);

    // Sequencer, index counter and output capture register.
    // out_valid and done are registered alongside the state transitions so
    // they change exactly on the edges that enter/leave SEND and DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_out_index <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= LOAD;
                        r_idx   <= '0;
                    end
                end
                LOAD: begin
                    // Read port is combinational, so rf_data is valid for
                    // rf_addr = r_idx in this same cycle.
                    r_out_data  <= rf_data;
                    r_out_index <= r_idx;
                    r_out_valid <= 1'b1;
                    r_state     <= SEND;
                end
                SEND: begin
                    // Without out_ready every output register simply holds.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_at_last) begin
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    // start is deliberately not sampled here; a held start
                    // is picked up from IDLE on the next cycle.
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rf_addr   = ((r_state == LOAD) || (r_state == SEND)) ? r_idx : '0;
    assign out_last  = (r_state == SEND) && w_at_last;
    assign busy      = (r_state != IDLE);
    assign halt_req  = busy;
    assign out_valid = r_out_valid;
    assign out_index = r_out_index;
    assign out_data  = r_out_data;
    assign done      = r_done;

endmodule : regfile_dump
`default_nettype wire
